// File: rtl/if_id_pkg.sv
// Shared types and defaults for the elastic IF/ID pipeline register.
// The entry struct is at the default widths; if_id_elastic builds a width-parametrised copy of it.
package if_id_pkg;

  localparam int INS_W_DEFAULT = 32;
  localparam int PC_W_DEFAULT  = 32;
  localparam logic [INS_W_DEFAULT-1:0] NOP_INSN_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INS_W_DEFAULT-1:0] ins;
    logic [PC_W_DEFAULT-1:0]  pc;
    logic                     valid;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_elastic_sat_counter.sv
// Saturating up-counter. It sticks at all-ones and is cleared synchronously.
// It updates on the falling edge so that it lines up with the pipeline registers.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(negedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_elastic.sv
// Elastic IF/ID register: valid/ready on both sides, main entry A and skid entry B, flush.
// The optional IF_ID_PERF_EN build adds saturating stall and bubble counters.
module if_id_elastic
  import if_id_pkg::*;
#(
  parameter int               INS_W    = INS_W_DEFAULT,
  parameter int               PC_W     = PC_W_DEFAULT,
  parameter logic [INS_W-1:0] NOP_INSN = INS_W'(NOP_INSN_DEFAULT),
  parameter int               CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] ins,
  input  logic [PC_W-1:0]  next_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] ins_out,
  output logic [PC_W-1:0]  next_pc_out
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  pc;
    logic             valid;
  } entry_t;

  entry_t a_q;
  entry_t b_q;
  logic   push;
  logic   pop;

  // Both handshake outputs come straight from flops, so ready never ripples back to IF.
  assign in_ready    = !b_q.valid;
  assign out_valid   = a_q.valid;
  assign ins_out     = a_q.valid ? a_q.ins : NOP_INSN;
  assign next_pc_out = a_q.pc;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(negedge CLK) begin
    if (RST) begin
      a_q.valid <= 1'b0;
      a_q.ins   <= NOP_INSN;
      a_q.pc    <= '0;
      b_q.valid <= 1'b0;
    end else if (flush) begin
      a_q.valid <= 1'b0;
      b_q.valid <= 1'b0;
    end else if (push && pop) begin
      a_q.ins   <= ins;
      a_q.pc    <= next_pc;
      a_q.valid <= 1'b1;
    end else if (pop) begin
      // An empty B must not overwrite the pc that ID last saw.
      if (b_q.valid) begin
        a_q <= b_q;
      end else begin
        a_q.valid <= 1'b0;
      end
      b_q.valid <= 1'b0;
    end else if (push) begin
      if (!a_q.valid) begin
        a_q.ins   <= ins;
        a_q.pc    <= next_pc;
        a_q.valid <= 1'b1;
      end else begin
        b_q.ins   <= ins;
        b_q.pc    <= next_pc;
        b_q.valid <= 1'b1;
      end
    end
  end

`ifdef IF_ID_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = a_q.valid & !out_ready;
  assign bubble_inc = !a_q.valid & !flush & !RST;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .clear (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (CLK),
    .clear (RST),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_elastic.sv
// Testbench for if_id_elastic. The reference model is a FIFO of at most two entries plus a last-pc register.
// The saturating counters are checked only when IF_ID_PERF_EN is defined.
module tb_if_id_elastic;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int          CW  = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   ins = '0;
  logic [31:0]   next_pc = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   ins_out;
  logic [31:0]   next_pc_out;
`ifdef IF_ID_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } item_t;

  item_t q[$];
  logic [31:0] m_pc = '0;
  int m_stall  = 0;
  int m_bubble = 0;

  if_id_elastic #(.INS_W(32), .PC_W(32), .NOP_INSN(32'h0000_0000), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ins         (ins),
    .next_pc     (next_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ins_out     (ins_out),
    .next_pc_out (next_pc_out)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_ins();
    return (q.size() > 0) ? q[0].ins : NOP;
  endfunction

  // Advances one falling edge, updates the model with the inputs seen at that edge, and lets the outputs settle.
  task automatic tick();
    bit do_push, do_pop;
    @(negedge CLK);
    if (RST) begin
      q.delete();
      m_pc = '0;
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (q.size() > 0 && !out_ready) m_stall = (m_stall < 15) ? m_stall + 1 : 15;
      if (q.size() == 0 && !flush) m_bubble = (m_bubble < 15) ? m_bubble + 1 : 15;
      if (flush) begin
        q.delete();
      end else begin
        do_push = in_valid && (q.size() < 2);
        do_pop  = (q.size() > 0) && out_ready;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{ins: ins, pc: next_pc});
      end
      if (q.size() > 0) m_pc = q[0].pc;
    end
    #2;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; ins = 32'hDEAD_BEEF; next_pc = 32'h1234; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (ins_out !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_ins_out got %h want 00000000", ins_out); end
    n_checks++; if (next_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_next_pc_out got %h want 0", next_pc_out); end
    RST = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] w;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      w = 32'h1111_1111 * i;
      in_valid = 1'b1; ins = w; next_pc = 32'h100 + 4 * i;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
      tick();
      n_checks++; if (ins_out !== w || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_ins_out[%0d] got %h/%0b want %h/1", i, ins_out, out_valid, w); end
      n_checks++; if (next_pc_out !== 32'h100 + 4 * i) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", i, next_pc_out, 32'h100 + 4 * i); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || ins_out !== NOP || next_pc_out !== 32'h110) begin n_fail++; $display("FAIL stream_drain got %0b/%h/%h want 0/%h/00000110", out_valid, ins_out, next_pc_out, NOP); end
  endtask

  task automatic test_stall_fill();
    out_ready = 1'b0;
    in_valid = 1'b1; ins = 32'hAAAA_0001; next_pc = 32'h200; tick();
    ins = 32'hAAAA_0002; next_pc = 32'h204; tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_in_ready got %0b want 0", in_ready); end
    ins = 32'hAAAA_0003; next_pc = 32'h208; tick();
    n_checks++; if (ins_out !== 32'hAAAA_0001 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_held got %h/%0b want aaaa0001/0", ins_out, in_ready); end
    out_ready = 1'b1; tick();
    n_checks++; if (ins_out !== 32'hAAAA_0002 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release1 got %h/%0b want aaaa0002/1", ins_out, in_ready); end
    tick();
    n_checks++; if (ins_out !== 32'hAAAA_0003 || next_pc_out !== 32'h208) begin n_fail++; $display("FAIL stall_release2 got %h/%h want aaaa0003/00000208", ins_out, next_pc_out); end
    in_valid = 1'b0; tick();
    n_checks++; if (out_valid !== 1'b0 || ins_out !== NOP) begin n_fail++; $display("FAIL stall_empty got %0b/%h want 0/%h", out_valid, ins_out, NOP); end
  endtask

  task automatic test_flush();
    logic [31:0] pc_before;
    out_ready = 1'b0;
    in_valid = 1'b1; ins = 32'hBBBB_0001; next_pc = 32'h300; tick();
    ins = 32'hBBBB_0002; next_pc = 32'h304; tick();
    pc_before = next_pc_out;
    flush = 1'b1; ins = 32'hDEAD_0001; next_pc = 32'h308; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_handshake got %0b/%0b want 0/1", out_valid, in_ready); end
    n_checks++; if (ins_out !== NOP || next_pc_out !== 32'h300 || pc_before !== 32'h300) begin n_fail++; $display("FAIL flush_outputs got %h/%h want %h/00000300", ins_out, next_pc_out, NOP); end
    out_ready = 1'b1; tick(); tick();
    n_checks++; if (out_valid !== 1'b0 || ins_out !== NOP) begin n_fail++; $display("FAIL flush_no_ghost got %0b/%h want 0/%h", out_valid, ins_out, NOP); end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    in_valid = 1'b1; ins = 32'hCCCC_0001; next_pc = 32'h400; tick();
    out_ready = 1'b1; ins = 32'hCCCC_0002; next_pc = 32'h404; tick();
    n_checks++; if (ins_out !== 32'hCCCC_0002 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL push_pop got %h/%0b/%0b want cccc0002/1/1", ins_out, out_valid, in_ready); end
    in_valid = 1'b0; tick();
    n_checks++; if (out_valid !== 1'b0 || next_pc_out !== 32'h404) begin n_fail++; $display("FAIL push_pop_drain got %0b/%h want 0/00000404", out_valid, next_pc_out); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; ins = 32'hEEEE_0001; next_pc = 32'h500; tick();
    ins = 32'hEEEE_0002; tick();
    RST = 1'b1; tick();
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ins_out !== NOP || next_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_mid_stall got %0b/%0b/%h/%h want 0/1/%h/0", out_valid, in_ready, ins_out, next_pc_out, NOP); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      RST       = ($urandom_range(0, 79) == 0);
      ins       = $urandom;
      next_pc   = $urandom;
      tick();
      n_checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          ins_out !== exp_ins() || next_pc_out !== m_pc) begin
        n_fail++; errs++;
        if (errs <= 8) $display("FAIL random[%0d] got v=%0b r=%0b ins=%h pc=%h want v=%0b r=%0b ins=%h pc=%h",
                                i, out_valid, in_ready, ins_out, next_pc_out, q.size() > 0, q.size() < 2, exp_ins(), m_pc);
      end
`ifdef IF_ID_PERF_EN
      n_checks++;
      if (stall_cnt !== CW'(m_stall) || bubble_cnt !== CW'(m_bubble)) begin
        n_fail++; errs++;
        if (errs <= 8) $display("FAIL random_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, bubble_cnt, m_stall, m_bubble);
      end
`endif
    end
    in_valid = 1'b0; flush = 1'b0; RST = 1'b0;
  endtask

`ifdef IF_ID_PERF_EN
  task automatic test_perf();
    RST = 1'b1; tick(); RST = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; ins = 32'hF00D_0001; next_pc = 32'h600; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL perf_stall_sat got %h want f", stall_cnt); end
    RST = 1'b1; tick(); RST = 1'b0;
    n_checks++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL perf_reset got %h/%h want 0/0", stall_cnt, bubble_cnt); end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush();
    test_push_pop();
    test_reset_mid_stall();
`ifdef IF_ID_PERF_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_elastic.md
Name: if_id_elastic

Overview:
- Parametrised successor to the IF/ID pipeline register.
- Adds valid/ready handshaking toward both the IF and ID stages, a 2-entry skid buffer, synchronous reset and a flush input.
- The IF stage can keep fetching while ID stalls on a hazard, with no combinational path from ID's ready back to IF.
- Sits between instruction-cache fetch (valid = cache hit) and the decoder.

Parameters:
- INS_W, 32, instruction width in bits.
- PC_W, 32, next-PC width in bits.
- NOP_INSN, 32'h00000000, instruction presented on ins_out when no valid entry is held (width INS_W).
- CNT_W, 16, width of the performance counters (used only with IF_ID_PERF_EN).

Ports:
- CLK  in  1  pipeline clock; all state updates on the falling edge, same as the existing pipeline registers.
- RST  in  1  synchronous, active-high reset, sampled on the falling edge of CLK.
- in_valid  in  1  IF has an instruction (cache hit).
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- ins  in  INS_W  fetched instruction.
- next_pc  in  PC_W  PC+4 of the fetched instruction.
- flush  in  1  branch/jump redirect; discard all held entries.
- out_valid  out  1  ins_out/next_pc_out hold a valid entry.
- out_ready  in  1  ID consumes this edge (low on hazard stall).
- ins_out  out  INS_W  instruction to ID.
- next_pc_out  out  PC_W  next PC to ID.
- stall_cnt  out  CNT_W  present only with IF_ID_PERF_EN.
- bubble_cnt  out  CNT_W  present only with IF_ID_PERF_EN.

Behaviour:
- Storage: main entry A (drives the outputs) and skid entry B. Each entry holds {ins, pc, valid}. Occupancy is 0, 1 or 2.
- out_valid = A.valid; in_ready = !B.valid. Both are registered; no input-to-output combinational path.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Latency: an entry pushed at falling edge N is visible on the outputs after edge N. Sustained throughput is 1 per cycle with out_ready held high.
- Priority at each falling edge is RST > flush > push/pop.
- RST: A.valid = B.valid = 0; ins_out = NOP_INSN; next_pc_out = 0; counters = 0.
- flush: A.valid = B.valid = 0; ins_out = NOP_INSN; next_pc_out holds its value. A simultaneous push is dropped. Counters are not cleared.
- pop only: A <- B (including valid); B.valid <- 0.
- push only, A empty: A <- input.
- push only, A full: B <- input, so in_ready drops on the next edge.
- push and pop together: A <- input. B is necessarily empty, because push requires in_ready.
- No push and no pop: hold all state.
- When A.valid = 0, ins_out = NOP_INSN and next_pc_out holds its last value.
- Full (occupancy 2): in_ready = 0. in_valid is ignored and IF must hold its request.
- Empty: out_valid = 0. out_ready is ignored.
- Reset asserted mid-stall behaves exactly as the RST case; no entry survives.
- Entries leave in strict FIFO order; none is duplicated or lost except by flush or RST.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined: two CNT_W saturating counters, updated on the falling edge and reset to 0 by RST.
  - stall_cnt increments when out_valid & !out_ready.
  - bubble_cnt increments when !out_valid & !flush & !RST.
  - Both hold at all-ones.
- Undefined: stall_cnt and bubble_cnt ports and logic are absent. Datapath behaviour is identical either way.

Decomposition:
- Package if_id_pkg: the entry struct typedef {ins, pc, valid}, and the default NOP_INSN constant.
- One sub-module, sat_counter (width parameter, inc/clear inputs), instantiated twice under IF_ID_PERF_EN.
- The skid logic stays inline.

Test Plan:
- Reset: assert RST for 2 edges with in_valid=1 -> out_valid=0, in_ready=1, ins_out=32'h00000000, next_pc_out=0.
- Stream: out_ready=1, push ins 0x11111111..0x44444444 on consecutive edges -> each appears one edge later, in order, with in_ready continuously 1.
- Stall fill: out_ready=0, push 0xAAAA0001 then 0xAAAA0002 -> in_ready=0 after the second edge. 0xAAAA0003 is held off. Raising out_ready yields 0001, 0002, 0003 in order.
- Flush while full (occupancy 2) with in_valid=1 on the same edge -> out_valid=0, in_ready=1, ins_out=NOP_INSN. The pushed instruction never appears.
- Push and pop on the same edge at occupancy 1 -> occupancy stays 1 and the new instruction is on ins_out after the edge.
- IF_ID_PERF_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 edges -> stall_cnt saturates at 4'hF. RST clears it to 0.
